// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM encoding and drain length.
package systolic_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_t;

   // Advances needed after the last activation so its partial sums leave the
   // bottom row: the deepest skew lane plus one trip through every column.
   function automatic int drain_len(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Upstream beat stream into the feeder: one element per PE row plus a last marker.
interface systolic_feeder_if #(
   parameter int ROWS       = 4,
   parameter int DATA_WIDTH = 8
) ();

   logic                       S_VALID;
   logic                       S_READY;
   logic [ROWS*DATA_WIDTH-1:0] S_DATA;
   logic                       S_LAST;

   modport master (output S_VALID, S_DATA, S_LAST, input S_READY);
   modport slave  (input S_VALID, S_DATA, S_LAST, output S_READY);

endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// Fixed-depth shift register that advances only on shift_en; DEPTH=0 is a wire.
module skew_delay_line #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  SYNC_RST,
   input  logic                  clr,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = &{1'b0, CLK, SYNC_RST, clr, shift_en};
         assign dout      = din;
      end else begin : g_shift
         logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

         // Shift one stage per array advance; hold on stalls so lanes stay aligned.
         always_ff @(posedge CLK) begin
            if (!SYNC_RST || clr) begin
               for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
            end else if (shift_en) begin
               stage_reg[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
            end
         end

         assign dout = stage_reg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Left-edge feeder for a weight-stationary PE array: weight preload, skewed
// activation streaming, then a zero drain that flushes the final partial sums.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                       CLK,
   input  logic                       SYNC_RST,
   input  logic                       START,
   systolic_feeder_if.slave           s_bus,
   output logic                       PE_EN,
   output logic                       PE_LOAD,
   output logic [ROWS*DATA_WIDTH-1:0] PE_DATA,
   output logic                       BUSY,
   output logic                       DONE
);

   localparam int BEAT_W    = $clog2(COLS + 1);
   localparam int DRAIN_W   = $clog2(ROWS + COLS);
   localparam int DRAIN_LEN = drain_len(ROWS, COLS);

   feeder_state_t              state_reg, state_next;
   logic [BEAT_W-1:0]          beat_cnt_reg, beat_cnt_next;
   logic [DRAIN_W-1:0]         drain_cnt_reg, drain_cnt_next;
   logic                       pe_en_reg, pe_en_next;
   logic                       pe_load_reg, pe_load_next;
   logic [ROWS*DATA_WIDTH-1:0] pe_data_reg, pe_data_next;
   logic                       done_reg, done_next;

   logic                       accept;
   logic                       advance;
   logic                       skew_clr;
   logic [ROWS*DATA_WIDTH-1:0] skew_in;
   logic [ROWS*DATA_WIDTH-1:0] skew_out;

   assign s_bus.S_READY = (state_reg == LOAD_W) || (state_reg == STREAM);
   assign accept        = s_bus.S_VALID && s_bus.S_READY;
   assign advance       = ((state_reg == STREAM) && accept) || (state_reg == DRAIN);
   assign skew_in       = (state_reg == DRAIN) ? '0 : s_bus.S_DATA;
   assign skew_clr      = (state_reg == IDLE) && START;

   // Row r sees its lane delayed by r advances, giving the diagonal wavefront.
   generate
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         skew_delay_line #(
            .DEPTH      (gi),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_skew (
            .CLK      (CLK),
            .SYNC_RST (SYNC_RST),
            .clr      (skew_clr),
            .shift_en (advance),
            .din      (skew_in[gi*DATA_WIDTH +: DATA_WIDTH]),
            .dout     (skew_out[gi*DATA_WIDTH +: DATA_WIDTH])
         );
      end
   endgenerate

   // Next-state and next registered outputs; PE_DATA holds unless something advances.
   always_comb begin
      state_next     = state_reg;
      beat_cnt_next  = beat_cnt_reg;
      drain_cnt_next = drain_cnt_reg;
      pe_en_next     = 1'b0;
      pe_load_next   = 1'b0;
      pe_data_next   = pe_data_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (START) begin
               state_next    = LOAD_W;
               beat_cnt_next = '0;
            end
         end
         LOAD_W: begin
            if (accept) begin
               pe_en_next    = 1'b1;
               pe_load_next  = 1'b1;
               pe_data_next  = s_bus.S_DATA;
               beat_cnt_next = beat_cnt_reg + 1'b1;
               if (beat_cnt_reg == BEAT_W'(COLS - 1)) state_next = STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               pe_en_next   = 1'b1;
               pe_data_next = skew_out;
               if (s_bus.S_LAST) begin
                  state_next     = DRAIN;
                  drain_cnt_next = DRAIN_W'(DRAIN_LEN);
               end
            end
         end
         DRAIN: begin
            pe_en_next     = 1'b1;
            pe_data_next   = skew_out;
            drain_cnt_next = drain_cnt_reg - 1'b1;
            if (drain_cnt_reg == DRAIN_W'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, counters and registered array controls; reset abandons any job.
   always_ff @(posedge CLK) begin
      if (!SYNC_RST) begin
         state_reg     <= IDLE;
         beat_cnt_reg  <= '0;
         drain_cnt_reg <= '0;
         pe_en_reg     <= 1'b0;
         pe_load_reg   <= 1'b0;
         pe_data_reg   <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         beat_cnt_reg  <= beat_cnt_next;
         drain_cnt_reg <= drain_cnt_next;
         pe_en_reg     <= pe_en_next;
         pe_load_reg   <= pe_load_next;
         pe_data_reg   <= pe_data_next;
         done_reg      <= done_next;
      end
   end

   assign PE_EN   = pe_en_reg;
   assign PE_LOAD = pe_load_reg;
   assign PE_DATA = pe_data_reg;
   assign DONE    = done_reg;
   assign BUSY    = (state_reg != IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder with a queue-based reference model and
// a per-cycle compare, plus directed literal checks from the test plan.
module tb_systolic_feeder;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int DW   = 8;
   localparam int W    = ROWS * DW;

   logic         CLK = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         pe_en, pe_load, busy, done;
   logic [W-1:0] pe_data;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   systolic_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) s_if ();

   systolic_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
      .CLK      (CLK),
      .SYNC_RST (rst_n),
      .START    (start),
      .s_bus    (s_if),
      .PE_EN    (pe_en),
      .PE_LOAD  (pe_load),
      .PE_DATA  (pe_data),
      .BUSY     (busy),
      .DONE     (done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 weight load, 2 stream, 3 drain
   int           m_phase = 0;
   int           m_wcnt  = 0;
   int           m_dleft = 0;
   logic [W-1:0] hist[$];          // every vector pushed into the skew since stream start
   logic         exp_en = 0, exp_load = 0, exp_done = 0;
   logic [W-1:0] exp_data = '0;

   // Lane r of the newest advance shows the vector from r advances earlier.
   function automatic logic [W-1:0] skew_view();
      logic [W-1:0] v = '0;
      logic [W-1:0] e;
      int n = hist.size() - 1;
      for (int r = 0; r < ROWS; r++) begin
         if (n - r >= 0) begin
            e = hist[n-r];
            v[r*DW +: DW] = e[r*DW +: DW];
         end
      end
      return v;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_phase = 0; exp_en = 0; exp_load = 0; exp_done = 0; exp_data = '0;
         hist.delete();
      end else begin
         exp_en = 0; exp_load = 0; exp_done = 0;
         case (m_phase)
            0: if (start) begin m_phase = 1; m_wcnt = 0; end
            1: if (s_if.S_VALID) begin
                  exp_en = 1; exp_load = 1; exp_data = s_if.S_DATA;
                  m_wcnt++;
                  if (m_wcnt == COLS) begin m_phase = 2; hist.delete(); end
               end
            2: if (s_if.S_VALID) begin
                  hist.push_back(s_if.S_DATA);
                  exp_en = 1; exp_data = skew_view();
                  if (s_if.S_LAST) begin m_phase = 3; m_dleft = ROWS + COLS - 1; end
               end
            default: begin
               hist.push_back('0);
               exp_en = 1; exp_data = skew_view();
               m_dleft--;
               if (m_dleft == 0) begin m_phase = 0; exp_done = 1; end
            end
         endcase
      end
   endtask

   // Advance the model on each rising edge, compare against the DUT on the falling edge.
   initial begin
      forever begin
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         chk("pe_en",   W'(pe_en),      W'(exp_en));
         chk("pe_load", W'(pe_load),    W'(exp_load));
         chk("pe_data", pe_data,        exp_data);
         chk("done",    W'(done),       W'(exp_done));
         chk("busy",    W'(busy),       W'(m_phase != 0));
         chk("s_ready", W'(s_if.S_READY), W'(m_phase == 1 || m_phase == 2));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (m_phase != 0 && n < budget) begin
         s_if.S_VALID = 1'($urandom);
         s_if.S_DATA  = W'($urandom);
         s_if.S_LAST  = 1'($urandom);
         step();
         n++;
      end
      s_if.S_VALID = 0; s_if.S_LAST = 0;
      if (m_phase != 0) chk("drain_timeout", W'(1), W'(0));
   endtask

   task automatic random_job(input int n_stream);
      int total = COLS + n_stream;
      int sent  = 0;
      int guard = 0;
      start = 1; s_if.S_VALID = 0; step(); start = 0;
      while (sent < total && guard < 200) begin
         s_if.S_VALID = ($urandom_range(0, 3) != 0);
         s_if.S_DATA  = W'($urandom);
         if (sent < COLS) s_if.S_LAST = 1'($urandom);
         else             s_if.S_LAST = (sent == total - 1);
         start = ($urandom_range(0, 7) == 0);
         step();
         if (s_if.S_VALID) sent++;
         guard++;
      end
      start = 0;
      wait_idle(40);
      repeat (2) step();
   endtask

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] held;
      int en_cnt;
      int got_done;
      int guard;

      s_if.S_VALID = 1; s_if.S_DATA = W'($urandom); s_if.S_LAST = 0;

      // Reset with S_VALID high: everything stays at zero.
      repeat (3) begin
         step();
         chk("rst_pe_data", pe_data, '0);
         chk("rst_s_ready", W'(s_if.S_READY), '0);
      end
      rst_n = 1; s_if.S_VALID = 0;
      step();
      chk("idle_busy", W'(busy), '0);

      // Weight load: 0x01..0x04 in every lane, unskewed with LOAD.
      start = 1; step(); start = 0;
      chk("load_ready", W'(s_if.S_READY), W'(1));
      for (int k = 1; k <= COLS; k++) begin
         s_if.S_VALID = 1;
         s_if.S_DATA  = {ROWS{8'(k)}};
         step();
         v = {ROWS{8'(k)}};
         chk("w_data", pe_data, v);
         chk("w_load", W'(pe_load), W'(1));
      end

      // Stream four beats, lane r = 0x10*(k+1)+r, with a 2-cycle stall after beat 1.
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < ROWS; r++) s_if.S_DATA[r*DW +: DW] = 8'(16 * (k + 1) + r);
         s_if.S_VALID = 1;
         s_if.S_LAST  = (k == 3);
         step();
         if (k == 1) begin
            v = 32'h0000_1120;
            chk("adv1_data", pe_data, v);
            held = pe_data;
            s_if.S_VALID = 0;
            repeat (2) begin
               step();
               chk("stall_en", W'(pe_en), '0);
               chk("stall_hold", pe_data, held);
            end
         end
      end
      v = 32'h1322_3140;
      chk("adv3_data", pe_data, v);
      s_if.S_VALID = 0; s_if.S_LAST = 0;
      chk("drain_ready", W'(s_if.S_READY), '0);

      // Drain: exactly ROWS+COLS-1 advances, DONE on the last.
      en_cnt = 0; got_done = 0; guard = 0;
      while (!got_done && guard < 30) begin
         step();
         if (pe_en) en_cnt++;
         if (done) got_done = 1;
         guard++;
      end
      chk("drain_done_seen", W'(got_done), W'(1));
      chk("drain_en_count", W'(en_cnt), W'(7));
      chk("drain_zero", pe_data, '0);
      step();
      chk("done_single", W'(done), '0);
      chk("done_busy", W'(busy), '0);

      // Randomized jobs of varying length.
      for (int j = 0; j < 8; j++) random_job($urandom_range(1, 6));

      // Reset in the middle of streaming, then a clean job.
      start = 1; step(); start = 0;
      for (int k = 0; k < COLS + 2; k++) begin
         s_if.S_VALID = 1; s_if.S_DATA = W'($urandom); s_if.S_LAST = 0;
         step();
      end
      s_if.S_VALID = 0;
      rst_n = 0; step(); rst_n = 1;
      chk("midrst_data", pe_data, '0);
      chk("midrst_done", W'(done), '0);
      chk("midrst_busy", W'(busy), '0);
      random_job(3);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
